// File: rtl/bitwise_pkg.sv
// rtl/bitwise_pkg.sv - shared opcode enum and default width for the bitwise logic unit
package bitwise_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } bw_op_t;

  localparam int DEFAULT_WIDTH = 7;

endpackage

// File: rtl/bitwise_logic_core.sv
// rtl/bitwise_logic_core.sv - combinational AND/OR/XOR/NOR selected by opcode
module bitwise_logic_core
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  bw_op_t           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      // Unknown opcodes in simulation load zero rather than propagating X.
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_operations.sv
// rtl/bitwise_operations.sv - registered bitwise logic unit, one-cycle latency
module bitwise_operations
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  bitwise_logic_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op_i    (bw_op_t'(op)),
    .a_i     (a),
    .b_i     (b),
    .result_o(q_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_bitwise_operations.sv
// tb/tb_bitwise_operations.sv - randomized self-checking bench for bitwise_operations
module tb_bitwise_operations;

  localparam int W = 7;

  logic         clk;
  logic         rst_n;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;

  int           pass_cnt;
  int           total_cnt;
  logic [W-1:0] exp_q;
  bit           started;

  bitwise_operations #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .op   (op),
    .a    (a),
    .b    (b),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: per-bit truth table indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_op(input int o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [3:0]   tt;
    logic [W-1:0] r;
    case (o)
      0:       tt = 4'b1000;
      1:       tt = 4'b1110;
      2:       tt = 4'b0110;
      default: tt = 4'b0001;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
  endtask

  // Model state: cleared asynchronously, otherwise the op of inputs seen at the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q = '0;
    else        exp_q = ref_op(int'(op), a, b);
  end

  always @(negedge clk) begin
    if (started) check("stream", q, exp_q);
  end

  task automatic drive(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
  endtask

  task automatic expect_next(input string name, input logic [W-1:0] want);
    @(posedge clk);
    #1;
    check(name, q, want);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    started   = 1'b0;
    exp_q     = '0;
    rst_n     = 1'b0;
    op        = 2'd0;
    a         = '0;
    b         = '0;

    check("model_and", ref_op(0, 7'b1010101, 7'b1100110), 7'b1000100);
    check("model_or",  ref_op(1, 7'b1010101, 7'b1100110), 7'b1110111);
    check("model_xor", ref_op(2, 7'b1010101, 7'b1100110), 7'b0110011);
    check("model_nor", ref_op(3, 7'b1111111, 7'b0000000), 7'b0000000);

    op = 2'd3;
    @(posedge clk);
    #1;
    check("reset_hold", q, 7'd0);
    started = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    drive(2'd3, 7'b0000000, 7'b0000000);
    expect_next("nor_zero", 7'b1111111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", q, 7'd0);
    expect_next("clear_held", 7'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(2'd0, 7'b1010101, 7'b1100110);
    expect_next("and", 7'b1000100);
    drive(2'd1, 7'b1010101, 7'b1100110);
    expect_next("or", 7'b1110111);
    drive(2'd2, 7'b1010101, 7'b1100110);
    expect_next("xor", 7'b0110011);
    drive(2'd3, 7'h7F, 7'h00);
    expect_next("nor_ones", 7'h00);
    drive(2'd3, 7'h00, 7'h00);
    expect_next("nor_zero2", 7'h7F);

    for (int i = 0; i < 24; i++) begin
      drive(2'(i % 4), W'($urandom), W'($urandom));
    end

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", q, 7'd0);
    drive(2'd2, 7'b1111000, 7'b1010101);
    rst_n = 1'b1;
    expect_next("post_release", 7'b0101101);

    for (int i = 0; i < 40; i++) begin
      drive(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    end
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
